// File: rtl/mmio_timer_responder.sv
// Memory-mapped prescaled timer on the core data port: CTRL/PRESCALE/COUNT/COMPARE/STATUS,
// combinational load path, byte/half/word stores with merge, sticky match and registered irq.
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic        d_wr_en,
  input  logic [2:0]  store_type,
  input  logic [2:0]  load_type,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT    = 3'd2,
    REG_COMPARE  = 3'd3,
    REG_STATUS   = 3'd4
  } reg_sel_e;

  localparam logic [PRESC_W-1:0] PSC_ONE = PRESC_W'(1);

  logic [2:0]         ctrl, ctrl_n;
  logic [PRESC_W-1:0] prescale, prescale_n;
  logic [PRESC_W-1:0] psc_cnt, psc_cnt_n;
  logic [31:0]        count, count_n;
  logic [31:0]        compare, compare_n;
  logic               match, match_n;
  logic               irq_n;

  logic [31:0] offset;
  reg_sel_e    sel;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [31:0] bmask;
  logic [31:0] merged;
  logic        wr_any;
  logic        we_ctrl, we_presc, we_count, we_compare, we_status;
  logic        w1c;
  logic        tick;
  logic        cmp_eq;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap far out of range.
  assign offset = dAddr - BASE_ADDR;
  assign hit    = (offset[31:5] == '0);
  assign sel    = reg_sel_e'(offset[4:2]);

  always_comb begin
    rd_word = '0;
    if (hit) begin
      case (sel)
        REG_CTRL:     rd_word[2:0] = ctrl;
        REG_PRESCALE: rd_word[PRESC_W-1:0] = prescale;
        REG_COUNT:    rd_word = count;
        REG_COMPARE:  rd_word = compare;
        REG_STATUS:   rd_word[0] = match;
        default:      rd_word = '0;
      endcase
    end
  end

  assign rd_byte = 8'(rd_word >> {offset[1:0], 3'b000});
  assign rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (load_type)
      3'b000:  rdata = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rdata = {{16{rd_half[15]}}, rd_half};
      3'b010:  rdata = rd_word;
      3'b100:  rdata = {24'd0, rd_byte};
      3'b101:  rdata = {16'd0, rd_half};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    be   = '0;
    wdat = '0;
    case (store_type)
      3'b000: begin
        be   = 4'b0001 << offset[1:0];
        wdat = {4{dWdata[7:0]}};
      end
      3'b001: begin
        if (!offset[0]) be = offset[1] ? 4'b1100 : 4'b0011;
        wdat = {2{dWdata[15:0]}};
      end
      3'b010: begin
        if (offset[1:0] == 2'b00) be = 4'b1111;
        wdat = dWdata;
      end
      default: begin
        be   = '0;
        wdat = '0;
      end
    endcase
  end

  assign bmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // Partial stores merge into the current (zero-padded) register image.
  assign merged = (rd_word & ~bmask) | (wdat & bmask);
  assign wr_any = hit & d_wr_en & (|be);

  assign we_ctrl    = wr_any && (sel == REG_CTRL);
  assign we_presc   = wr_any && (sel == REG_PRESCALE);
  assign we_count   = wr_any && (sel == REG_COUNT);
  assign we_compare = wr_any && (sel == REG_COMPARE);
  assign we_status  = wr_any && (sel == REG_STATUS);
  assign w1c        = we_status & be[0] & wdat[0];

  assign tick   = ctrl[0] && (psc_cnt == prescale);
  assign cmp_eq = (count == compare);

  always_comb begin
    ctrl_n     = we_ctrl ? merged[2:0] : ctrl;
    prescale_n = we_presc ? merged[PRESC_W-1:0] : prescale;
    compare_n  = we_compare ? merged : compare;

    psc_cnt_n = psc_cnt + PSC_ONE;
    if (!ctrl[0] || tick || we_presc) psc_cnt_n = '0;

    count_n = count;
    if (we_count) begin
      count_n = merged;
    end else if (tick) begin
      count_n = (cmp_eq && ctrl[1]) ? 32'd0 : count + 32'd1;
    end

    match_n = (tick & cmp_eq) | (match & ~w1c);
    irq_n   = match_n & ctrl_n[2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= '0;
      psc_cnt  <= '0;
      count    <= '0;
      compare  <= '0;
      match    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ctrl     <= ctrl_n;
      prescale <= prescale_n;
      psc_cnt  <= psc_cnt_n;
      count    <= count_n;
      compare  <= compare_n;
      match    <= match_n;
      irq      <= irq_n;
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboarded directed bench for mmio_timer_responder: stimulus queues expectations,
// a negedge monitor drains and compares them.
module tb_mmio_timer_responder;

  localparam logic [31:0] B = 32'h1000_0000;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam int SEL_RDATA = 0, SEL_HIT = 1, SEL_IRQ = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic        d_wr_en = 1'b0;
  logic [2:0]  store_type = '0;
  logic [2:0]  load_type = 3'b010;
  logic        hit;
  logic [31:0] rdata;
  logic        irq;

  mmio_timer_responder #(.BASE_ADDR(B), .PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .dAddr(dAddr), .dWdata(dWdata), .d_wr_en(d_wr_en),
    .store_type(store_type), .load_type(load_type), .hit(hit), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  chk_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        SEL_RDATA: mon_act = rdata;
        SEL_HIT:   mon_act = {31'd0, hit};
        default:   mon_act = {31'd0, irq};
      endcase
      n_checks++;
      if (mon_act !== mon_e.exp)
        $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
      else
        n_pass++;
    end
  end

  function automatic void expect_val(int sel, logic [31:0] exp, string name);
    chk_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic op_idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      d_wr_en = 1'b0;
    end
  endtask

  task automatic op_wr(logic [31:0] addr, logic [31:0] data, logic [2:0] st);
    @(posedge clk); #1;
    dAddr = addr; dWdata = data; store_type = st; d_wr_en = 1'b1;
  endtask

  task automatic op_rd(logic [31:0] addr, logic [2:0] lt, logic [31:0] exp,
                       logic exp_hit, string name);
    @(posedge clk); #1;
    d_wr_en = 1'b0; dAddr = addr; load_type = lt;
    expect_val(SEL_RDATA, exp, name);
    expect_val(SEL_HIT, {31'd0, exp_hit}, {name, "_hit"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset asserted: combinational decode still live
    op_rd(B + 32'h08, LW, 32'h0, 1'b1, "rst_lw_count");
    expect_val(SEL_IRQ, 32'h0, "rst_irq");
    @(posedge clk); #1; reset = 1'b1;

    // Run with compare=0, prescale=0 so match/irq set, then pulse reset
    op_wr(B + 32'h00, 32'h7, SW);
    op_idle(2);
    op_rd(B + 32'h10, LW, 32'h1, 1'b1, "pre_rst_status");
    expect_val(SEL_IRQ, 32'h1, "pre_rst_irq");
    @(posedge clk); #1; reset = 1'b0;
    expect_val(SEL_IRQ, 32'h0, "rst_pulse_irq");
    @(posedge clk); #1; reset = 1'b1;
    op_rd(B + 32'h08, LW, 32'h0, 1'b1, "post_rst_count");
    op_rd(B + 32'h00, LW, 32'h0, 1'b1, "post_rst_ctrl");
    op_rd(B + 32'h10, LW, 32'h0, 1'b1, "post_rst_status");
    expect_val(SEL_IRQ, 32'h0, "post_rst_irq");

    // Basic count: PRESCALE=3, COMPARE=2, CTRL=en|reload|irq_en
    op_wr(B + 32'h04, 32'd3, SW);
    op_wr(B + 32'h0C, 32'd2, SW);
    op_wr(B + 32'h00, 32'h7, SW);
    op_rd(B + 32'h08, LW, 32'd0, 1'b1, "cnt_c0");      // cycle 0
    op_idle(3);
    op_rd(B + 32'h08, LW, 32'd1, 1'b1, "cnt_c4");      // cycle 4
    op_idle(3);
    op_rd(B + 32'h08, LW, 32'd2, 1'b1, "cnt_c8");      // cycle 8
    expect_val(SEL_IRQ, 32'h0, "irq_c8");
    op_rd(B + 32'h10, LW, 32'd0, 1'b1, "status_c9");
    op_idle(2);
    op_rd(B + 32'h10, LW, 32'd1, 1'b1, "status_c12");  // cycle 12
    expect_val(SEL_IRQ, 32'h1, "irq_c12");
    op_rd(B + 32'h08, LW, 32'd0, 1'b1, "cnt_reload");  // cycle 13

    // Clear match, then W1C in the same cycle as the next match (set wins)
    op_wr(B + 32'h10, 32'h1, SW);                       // cycle 14
    op_rd(B + 32'h10, LW, 32'd0, 1'b1, "w1c_status");  // cycle 15
    expect_val(SEL_IRQ, 32'h0, "w1c_irq");
    op_idle(7);                                         // cycles 16..22
    op_wr(B + 32'h10, 32'h1, SW);                       // cycle 23, commits on match edge
    op_rd(B + 32'h10, LW, 32'd1, 1'b1, "setwins_status");
    expect_val(SEL_IRQ, 32'h1, "setwins_irq");
    op_idle(2);                                         // cycles 25,26
    op_wr(B + 32'h08, 32'd100, SW);                     // cycle 27, tick edge E28
    op_rd(B + 32'h08, LW, 32'd100, 1'b1, "cnt_wr_wins");
    op_idle(3);                                         // cycles 29..31
    op_rd(B + 32'h08, LW, 32'd101, 1'b1, "cnt_after_wr");

    // Byte/half access on COMPARE with the timer stopped
    op_wr(B + 32'h00, 32'h0, SW);
    op_wr(B + 32'h0C, 32'h8081_7F80, SW);
    op_rd(B + 32'h0C, LW,  32'h8081_7F80, 1'b1, "cmp_lw");
    op_rd(B + 32'h0C, LB,  32'hFFFF_FF80, 1'b1, "cmp_lb");
    op_rd(B + 32'h0D, LBU, 32'h0000_007F, 1'b1, "cmp_lbu");
    op_rd(B + 32'h0E, LH,  32'hFFFF_8081, 1'b1, "cmp_lh");
    op_rd(B + 32'h0E, LHU, 32'h0000_8081, 1'b1, "cmp_lhu");
    op_wr(B + 32'h0D, 32'hAAAA_AA55, SB);
    op_rd(B + 32'h0C, LW,  32'h8081_5580, 1'b1, "cmp_sb");
    op_wr(B + 32'h0D, 32'h0000_1234, SH);
    op_rd(B + 32'h0C, LW,  32'h8081_5580, 1'b1, "cmp_sh_misalign");
    op_wr(B + 32'h0E, 32'hFFFF_FFFF, SW);
    op_rd(B + 32'h0C, LW,  32'h8081_5580, 1'b1, "cmp_sw_misalign");
    op_wr(B + 32'h0C, 32'h1234_5678, 3'b011);
    op_rd(B + 32'h0C, LW,  32'h8081_5580, 1'b1, "cmp_bad_store");
    op_wr(B + 32'h0E, 32'h0000_ABCD, SH);
    op_rd(B + 32'h0C, LW,  32'hABCD_5580, 1'b1, "cmp_sh_hi");
    op_wr(B + 32'h0C, 32'h8081_5580, SW);

    // No reload, wrap past FFFF_FFFF
    op_wr(B + 32'h10, 32'h1, SW);
    op_rd(B + 32'h10, LW, 32'd0, 1'b1, "wrap_status_clr");
    op_wr(B + 32'h08, 32'hFFFF_FFFE, SW);
    op_wr(B + 32'h0C, 32'd5, SW);
    op_wr(B + 32'h04, 32'd0, SW);
    op_wr(B + 32'h00, 32'h1, SW);
    op_rd(B + 32'h08, LW, 32'hFFFF_FFFE, 1'b1, "wrap_c0");
    op_rd(B + 32'h08, LW, 32'hFFFF_FFFF, 1'b1, "wrap_c1");
    op_rd(B + 32'h08, LW, 32'h0000_0000, 1'b1, "wrap_c2");
    op_rd(B + 32'h08, LW, 32'h0000_0001, 1'b1, "wrap_c3");
    op_rd(B + 32'h10, LW, 32'd0, 1'b1, "wrap_status");
    expect_val(SEL_IRQ, 32'h0, "wrap_irq");

    // Decode and reserved space
    op_wr(B + 32'h00, 32'h0, SW);
    op_wr(B + 32'h0C, 32'h8081_5580, SW);
    op_rd(B + 32'h20, LW, 32'h0, 1'b0, "miss_above");
    op_rd(B - 32'h4,  LW, 32'h0, 1'b0, "miss_below");
    op_wr(B + 32'h20, 32'h0000_0007, SW);
    op_wr(B + 32'h2C, 32'hDEAD_BEEF, SW);
    op_wr(B - 32'h14, 32'h1111_1111, SW);
    op_rd(B + 32'h00, LW, 32'h0, 1'b1, "miss_ctrl_kept");
    op_rd(B + 32'h0C, LW, 32'h8081_5580, 1'b1, "miss_cmp_kept");
    op_wr(B + 32'h14, 32'hFFFF_FFFF, SW);
    op_rd(B + 32'h14, LW, 32'h0, 1'b1, "rsvd_14");
    op_rd(B + 32'h18, LW, 32'h0, 1'b1, "rsvd_18");
    op_wr(B + 32'h04, 32'hFFFF_FFFF, SW);
    op_rd(B + 32'h04, LW, 32'h0000_FFFF, 1'b1, "presc_unused");
    op_wr(B + 32'h00, 32'hFFFF_FFF8, SW);
    op_rd(B + 32'h00, LW, 32'h0, 1'b1, "ctrl_unused");

    op_idle(2);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
